chipset_bus_controller: RTL
===========================

Name: chipset_bus_controller

Overview:
Parametrised bus-cycle controller for the chipset. It does two jobs:
- Inserts programmable wait states on the CPU RDY line, separately for memory and I/O cycles.
- Arbitrates NUM_MASTERS bus requesters (DMA, video) onto the CPU HOLD/HLDA handshake with round-robin priority.

It sits between the 8088 bus-control signals and the chipset top level. It replaces the fixed single-master HOLD/RDY logic.

Parameters:
NUM_MASTERS, 2, number of bus requesters (1..8)
WAIT_WIDTH, 4, width of the wait-state counter
MEM_WAIT, 1, wait states inserted on memory cycles (< 2^WAIT_WIDTH)
IO_WAIT, 4, wait states inserted on I/O cycles (< 2^WAIT_WIDTH)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
cpu_clock_posedge  input  1  one-clock strobe marking a CPU clock rising edge; all state advances only on this strobe
ALE  input  1  address latch enable from the CPU
IO_OR_M  input  1  1 = I/O cycle, 0 = memory cycle
RD_N  input  1  read strobe, active-low
WR_N  input  1  write strobe, active-low
ext_wait  input  1  external wait request; while 1, holds RDY low in the active cycle
RDY  output  1  ready to the CPU
HOLD  output  1  hold request to the CPU
HLDA  input  1  hold acknowledge from the CPU
bus_req  input  NUM_MASTERS  per-master bus request, level
bus_grant  output  NUM_MASTERS  one-hot grant
wait_active  output  1  1 while the wait counter is non-zero

Behaviour:
Reset:
- Applies asynchronously.
- RDY=1, HOLD=0, bus_grant=0, wait_active=0.
- Wait counter=0, arbiter=IDLE, RR pointer=0, io latch=0.

Strobing:
- Every register update is qualified by cpu_clock_posedge.
- Between strobes, all state is held.

Wait-state path:
- ALE=1 on a strobe: latch IO_OR_M into io_lat and set cycle_armed=1.
- On the first strobe with cycle_armed=1 and (RD_N=0 or WR_N=0):
  - load counter with io_lat ? IO_WAIT : MEM_WAIT;
  - clear cycle_armed;
  - RDY=0 from this strobe if the loaded value is non-zero.
- Each later strobe with counter>0: decrement.
- RDY is combinational: RDY = (counter==0) && !(ext_wait && strobe_active), where strobe_active = !RD_N || !WR_N.
- A zero wait value gives no RDY drop (unless ext_wait is 1).
- The counter saturates at 0 and never wraps.
- ALE=1 while the counter is non-zero: re-latch io_lat; the counter is unaffected.
- Counter value is used as loaded: WAIT_WIDTH bits, no truncation, because of the parameter constraint.

Arbiter FSM:
- IDLE:
  - Any bus_req bit set → REQ, HOLD=1.
  - Winner = first set bit at or after the RR pointer, searching upward with wrap-around from NUM_MASTERS-1 to 0.
  - The winner index is captured in this transition.
- REQ: HOLD=1; HLDA=1 on a strobe → GRANT, bus_grant[winner]=1.
- GRANT:
  - HOLD=1 and the grant is held while bus_req[winner]=1.
  - bus_req[winner]=0 → RELEASE: bus_grant=0, HOLD=0, RR pointer = winner+1 mod NUM_MASTERS.
- RELEASE: HLDA=0 → IDLE. Requests are ignored until then; no back-to-back grant without HLDA dropping.

Arbiter boundary rules:
- Winner's request drops in REQ before HLDA: stay in REQ; on HLDA, go directly to RELEASE without granting, and do not advance the pointer.
- Other requests arriving in REQ/GRANT are held off. Levels are sampled fresh in IDLE.
- bus_grant is always one-hot or zero.
- HOLD and the wait counter are independent. The CPU decides when to grant HLDA.
- reset_n asserted mid-cycle or mid-grant: immediate return to reset values.

Test Plan:
- Memory cycle:
  - stimulus: IO_OR_M=0, MEM_WAIT=1; ALE strobe, then RD_N=0;
  - response: RDY low for exactly 1 strobe after the RD_N strobe; wait_active pulses 1 strobe.
- I/O write:
  - stimulus: IO_OR_M=1, IO_WAIT=4; WR_N=0;
  - response: RDY low for 4 strobes. With ext_wait=1 for 2 strobes after the count expires, RDY stays low 2 more.
- Strobe gating:
  - stimulus: cpu_clock_posedge=1 only every 3rd clock;
  - response: the counter changes only on strobe clocks; RDY timing in strobes is identical to the previous case.
- Round robin, NUM_MASTERS=3:
  - stimulus: bus_req=3'b101 held, HLDA follows HOLD one strobe later;
  - response: grants in order 001, 100, 001. Each grant ends when that bit drops; HOLD=0 between grants until HLDA=0.
- Withdrawn request:
  - stimulus: bus_req[0] rises then falls before HLDA;
  - response: no bus_grant bit ever set; HOLD drops after HLDA; RR pointer unchanged (next req[0] wins again).
- Reset mid-grant:
  - stimulus: reset_n=0 during GRANT with a counter of 3;
  - response: HOLD=0, bus_grant=0, RDY=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/chipset_bus_controller.sv
// chipset_bus_controller
// Bus-cycle controller sitting between the 8088 bus-control signals and the
// chipset top level. It stretches CPU bus cycles with programmable wait states
// (separate counts for memory and I/O cycles) and arbitrates NUM_MASTERS bus
// requesters onto the CPU HOLD/HLDA handshake with round-robin priority.
// All state advances only on cpu_clock_posedge strobes.
//
// Ports:
//   clock              system clock
//   reset_n            asynchronous reset, active-low
//   cpu_clock_posedge  one-clock strobe marking a CPU clock rising edge
//   ALE                address latch enable from the CPU
//   IO_OR_M            1 = I/O cycle, 0 = memory cycle
//   RD_N, WR_N         read / write strobes, active-low
//   ext_wait           external wait request, holds RDY low in an active cycle
//   RDY                ready to the CPU
//   HOLD               hold request to the CPU
//   HLDA               hold acknowledge from the CPU
//   bus_req            per-master bus request levels
//   bus_grant          one-hot grant (or zero)
//   wait_active        1 while the wait counter is non-zero
module chipset_bus_controller #(
   parameter int NUM_MASTERS = 2,
   parameter int WAIT_WIDTH  = 4,
   parameter int MEM_WAIT    = 1,
   parameter int IO_WAIT     = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cpu_clock_posedge,
   input  logic                   ALE,
   input  logic                   IO_OR_M,
   input  logic                   RD_N,
   input  logic                   WR_N,
   input  logic                   ext_wait,
   output logic                   RDY,
   output logic                   HOLD,
   input  logic                   HLDA,
   input  logic [NUM_MASTERS-1:0] bus_req,
   output logic [NUM_MASTERS-1:0] bus_grant,
   output logic                   wait_active
);

   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [WAIT_WIDTH-1:0] MEM_WAIT_VAL = WAIT_WIDTH'(MEM_WAIT);
   localparam logic [WAIT_WIDTH-1:0] IO_WAIT_VAL  = WAIT_WIDTH'(IO_WAIT);
   localparam logic [PTR_W-1:0]      LAST_MASTER  = PTR_W'(NUM_MASTERS - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_GRANT   = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   logic [WAIT_WIDTH-1:0] wait_count;
   logic                  io_lat;
   logic                  cycle_armed;
   logic                  strobe_active;
   logic                  load_cycle;
   logic [WAIT_WIDTH-1:0] load_value;

   logic [1:0]       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] rr_winner;
   logic             rr_found;
   logic [PTR_W-1:0] next_ptr;

   // A bus cycle is only counted once: the first strobe after ALE that sees
   // a read or write strobe loads the counter and disarms the cycle.
   assign strobe_active = !RD_N || !WR_N;
   assign load_cycle    = cycle_armed && strobe_active;
   assign load_value    = io_lat ? IO_WAIT_VAL : MEM_WAIT_VAL;

   // RDY is combinational so the drop is visible in the same strobe that
   // loads a non-zero count, and an external wait acts without latency.
   assign RDY         = (wait_count == '0) && !(ext_wait && strobe_active);
   assign wait_active = (wait_count != '0);

   // Wait-state path: latch the cycle type on ALE, load on the first
   // read/write strobe, then count down to zero and stop there. An ALE
   // during a count only re-latches the cycle type.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_count  <= '0;
         io_lat      <= 1'b0;
         cycle_armed <= 1'b0;
      end else if (cpu_clock_posedge) begin
         if (ALE) begin
            io_lat      <= IO_OR_M;
            cycle_armed <= 1'b1;
         end else if (load_cycle) begin
            cycle_armed <= 1'b0;
         end
         if (load_cycle) begin
            wait_count <= load_value;
         end else if (wait_count != '0) begin
            wait_count <= wait_count - 1'b1;
         end
      end
   end

   // Round-robin search: first requesting master at or above the pointer,
   // wrapping from the top index back to 0.
   always_comb begin
      int unsigned idx;
      rr_found  = 1'b0;
      rr_winner = '0;
      idx       = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_MASTERS) begin
            idx = idx - NUM_MASTERS;
         end
         if (!rr_found && bus_req[idx]) begin
            rr_found  = 1'b1;
            rr_winner = PTR_W'(idx);
         end
      end
   end

   assign next_ptr = (winner == LAST_MASTER) ? '0 : winner + 1'b1;

   // Arbiter FSM. The winner is frozen on leaving IDLE so later requests
   // cannot steal the grant. A request withdrawn before HLDA still waits
   // for HLDA (the CPU has already been asked), then releases without a
   // grant and without moving the pointer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         rr_ptr <= '0;
         winner <= '0;
      end else if (cpu_clock_posedge) begin
         case (state)
            ST_IDLE: begin
               if (rr_found) begin
                  winner <= rr_winner;
                  state  <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (HLDA) begin
                  state <= bus_req[winner] ? ST_GRANT : ST_RELEASE;
               end
            end
            ST_GRANT: begin
               if (!bus_req[winner]) begin
                  rr_ptr <= next_ptr;
                  state  <= ST_RELEASE;
               end
            end
            default: begin
               if (!HLDA) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign HOLD = (state == ST_REQ) || (state == ST_GRANT);

   // Grant decode is combinational from state so reset clears it at once.
   always_comb begin
      bus_grant = '0;
      if (state == ST_GRANT) begin
         bus_grant[winner] = 1'b1;
      end
   end

endmodule
